// File: rtl/pix_uart_tx_pkg.sv
// Shared definitions for the pixel UART transmitter: FSM states, baud and frame constants.
// Frame length depends on UART_TX_PARITY_EN (11 bits when defined, 10 bits otherwise).
package pix_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_PARITY
    } tx_state_e;

    localparam int unsigned DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                 input int unsigned bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/pix_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO with extra-MSB pointers.
module pix_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic        do_wr;
    logic        do_rd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A write into a full FIFO is allowed when the head is being popped on the same edge.
    assign do_wr = wr_en && (!full || rd_en);
    assign do_rd = rd_en && !empty;

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/pix_uart_tx.sv
// Buffered 8N1 UART transmitter for the filtered pixel stream.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between DATA and STOP.
module pix_uart_tx
    import pix_uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned UART_BPS   = 9600,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       tx,
    output logic       tx_busy,
    output logic       po_overflow
);

    localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int unsigned BW           = $clog2(BAUD_CNT_MAX + 1);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_CNT_MAX - 1);
    localparam logic [2:0]    LAST_BIT   = 3'(DATA_BITS - 1);

    tx_state_e   state_q;
    logic [BW-1:0] baud_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        busy_q;
    logic        ovf_q;
`ifdef UART_TX_PARITY_EN
    logic        parity_q;
`endif

    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;
    logic        bit_end;
    logic        pop;
    logic        drop;

    pix_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_en     (pi_flag),
        .wr_data   (pi_data),
        .rd_en     (pop),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bit_end = (baud_cnt_q == BAUD_LAST);
    assign pop     = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));
    assign drop    = pi_flag && fifo_full && !pop;

    // tx is driven from the current state, so the line trails the FSM by one cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            busy_q     <= (state_q != ST_IDLE) || !fifo_empty;
            baud_cnt_q <= ((state_q == ST_IDLE) || bit_end) ? '0 : baud_cnt_q + 1'b1;
            if (drop) ovf_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^fifo_rd_data;
`endif
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    tx_q <= 1'b0;
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    tx_q <= shift_q[0];
                    if (bit_end) begin
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    tx_q <= parity_q;
                    if (bit_end) state_q <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        if (pop) begin
                            shift_q <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                            parity_q <= ^fifo_rd_data;
`endif
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx          = tx_q;
    assign tx_busy     = busy_q;
    assign po_overflow = ovf_q;

endmodule
